// File: rtl/uart_tx_framer_pkg.sv
// Shared types and constants for the UART transmit framer.
// Frame bit count follows the UART_TX_PARITY_EN build option.
package DataTypes;

  localparam int DEFAULT_DATA_W = 8;

  typedef logic bit_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartTxState_t;

`ifdef UART_TX_PARITY_EN
  localparam int bitspertx = DEFAULT_DATA_W + 3;
`else
  localparam int bitspertx = DEFAULT_DATA_W + 2;
`endif

  typedef logic [DEFAULT_DATA_W-1:0] uartData_t;

endpackage

// File: rtl/uart_tx_framer_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last clock of each serial bit with a one-cycle bit_tick.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == CNT_LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_tick = enable && (count == CNT_LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit before the stop bit.
module uart_tx_framer
  import DataTypes::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  uartTxState_t      state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [IDX_W-1:0]  bit_idx, bit_idx_next;
  logic              serial_next;
  logic              handshake;
  logic              bit_tick;
  bit_t              parity_q;

  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
  assign handshake = tx_valid && tx_ready;
  assign tx_done   = (state == STOP) && bit_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (handshake),
    .enable  (tx_busy),
    .bit_tick(bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is captured with the word because the shift register empties as it sends.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (handshake) begin
      parity_q <= ^tx_data;
    end
  end
`else
  assign parity_q = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (handshake) begin
          shreg_next   = tx_data;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shreg_next = shreg >> 1;
          if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The line level is registered from the upcoming state so it moves with the state.
    serial_next = 1'b1;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shreg_next[0];
      PARITY:  serial_next = parity_q;
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_idx   <= bit_idx_next;
      tx_serial <= serial_next;
    end
  end

endmodule
